// File: rtl/ram_sdp_pipe.sv
// ram_sdp_pipe: single-clock simple-dual-port RAM with byte enables, RD_LAT 1/2 read pipe and post-reset self-clear
// Define RAM_PARITY_EN to store one even-parity bit per byte and flag mismatches on perr; `do` is a keyword, so read data is dout
module ram_sdp_pipe #(
  parameter int    DWIDTH    = 16,
  parameter int    AWIDTH    = 7,
  parameter int    RD_LAT    = 1,
  parameter string COLLISION = "READ_FIRST",
  parameter string RAM_TYPE  = "block"
) (
  input  logic                  clk,
  input  logic                  reset_n,
  output logic                  init_busy,
  input  logic                  wren,
  input  logic [AWIDTH-1:0]     wraddr,
  input  logic [DWIDTH-1:0]     di,
  input  logic [DWIDTH/8-1:0]   wbe,
  input  logic                  rden,
  input  logic [AWIDTH-1:0]     rdaddr,
  output logic [DWIDTH-1:0]     dout,
  output logic                  do_valid,
  input  logic                  par_inj,
  output logic                  perr
);
  localparam int DEPTH = 1 << AWIDTH;
  localparam int NB = DWIDTH / 8;
`ifdef RAM_PARITY_EN
  localparam int MW = DWIDTH + NB;
`else
  localparam int MW = DWIDTH;
  logic unused_par;
  assign unused_par = par_inj;
`endif
  localparam bit WF = (COLLISION == "WRITE_FIRST");
  localparam string unused_ram_type = RAM_TYPE;
  typedef enum logic {CLEAR, READY} state_t;
  state_t state;
  logic [AWIDTH-1:0] cnt, waddr;
  logic clearing, wen, acc, we, pv, perr_c;
  logic [MW-1:0] wdata, wmask, rword, pword;
  (* ram_style = RAM_TYPE *) logic [MW-1:0] mem [DEPTH];
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= CLEAR;
      cnt <= '0;
      init_busy <= 1'b1;
    end else if (state == CLEAR) begin
      cnt <= cnt + 1'b1;
      if (cnt == {AWIDTH{1'b1}}) begin
        state <= READY;
        init_busy <= 1'b0;
      end
    end
  end
  assign clearing = (state == CLEAR);
  assign wen = wren & ~clearing;
  assign acc = rden & ~clearing;
  assign we = clearing | wen;
  assign waddr = clearing ? cnt : wraddr;
  // during CLEAR every byte (and its parity bit) is forced to zero
  always_comb begin
    wdata = '0;
    wmask = '0;
    for (int i = 0; i < NB; i++) begin
      wmask[8*i +: 8] = {8{clearing | wbe[i]}};
      wdata[8*i +: 8] = clearing ? 8'h00 : di[8*i +: 8];
`ifdef RAM_PARITY_EN
      wmask[DWIDTH+i] = clearing | wbe[i];
      wdata[DWIDTH+i] = ~clearing & (^di[8*i +: 8] ^ par_inj);
`endif
    end
  end
  always_ff @(posedge clk)
    if (we) mem[waddr] <= (mem[waddr] & ~wmask) | (wdata & wmask);
  assign rword = (WF && wen && wraddr == rdaddr) ? ((mem[rdaddr] & ~wmask) | (wdata & wmask)) : mem[rdaddr];
  generate
    if (RD_LAT == 2) begin : g_lat2
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          pv <= 1'b0;
          pword <= '0;
        end else begin
          pv <= acc;
          if (acc) pword <= rword;
        end
      end
    end else begin : g_lat1
      assign pv = acc;
      assign pword = rword;
    end
  endgenerate
  always_comb begin
    perr_c = 1'b0;
`ifdef RAM_PARITY_EN
    for (int i = 0; i < NB; i++) perr_c = perr_c | (^pword[8*i +: 8] ^ pword[DWIDTH+i]);
`endif
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dout <= '0;
      do_valid <= 1'b0;
      perr <= 1'b0;
    end else begin
      do_valid <= pv;
      perr <= pv & perr_c;
      if (pv) dout <= pword[DWIDTH-1:0];
    end
  end
endmodule
